mem_stage: RTL and testbench

//  Pipeline stage directly downstream of AGEX. Takes the ALU result / effective address
//  and executes loads and stores against a data memory through a req/ack handshake.

---
 rtl/mem_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: executes loads/stores over a req/ack data-memory handshake and registers results into the MEM->WB latch.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
`ifndef IOPBITS
`define IOPBITS 6
`endif
`ifndef LB_I
`define ADDI_I `IOPBITS'(1)
`define LB_I   `IOPBITS'(16)
`define LH_I   `IOPBITS'(17)
`define LW_I   `IOPBITS'(18)
`define LBU_I  `IOPBITS'(19)
`define LHU_I  `IOPBITS'(20)
`define SB_I   `IOPBITS'(21)
`define SH_I   `IOPBITS'(22)
`define SW_I   `IOPBITS'(23)
`endif

module mem_stage #(
  parameter int unsigned DBITS          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 agex_valid,
  input  logic [`IOPBITS-1:0]  agex_op,
  input  logic [DBITS-1:0]     agex_result,
  input  logic [DBITS-1:0]     agex_st_data,
  input  logic [4:0]           agex_rd,
  input  logic                 agex_wr_reg,
  output logic                 stall_agex,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [DBITS-1:0]     dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [DBITS-1:0]     dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [DBITS-1:0]     dmem_rdata,
  output logic                 mem_valid,
  output logic [4:0]           mem_rd,
  output logic                 mem_wr_reg,
  output logic [DBITS-1:0]     mem_wdata,
  output logic                 mem_err
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;

  logic                accept, is_mem, is_store, done, abort;
  logic [3:0]          be_nx;
  logic [DBITS-1:0]    wd_nx, rshift, load_val;
  logic [4:0]          lane_sh;
  logic [`IOPBITS-1:0] req_op;
  logic [1:0]          req_lane;
  logic [4:0]          req_rd;
  logic                req_wr_reg;

  assign accept   = agex_valid & (state == IDLE);
  assign is_mem   = (agex_op >= `LB_I) && (agex_op <= `SW_I);
  assign is_store = (agex_op == `SB_I) || (agex_op == `SH_I) || (agex_op == `SW_I);
  assign done     = (state == WAIT) & dmem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // Abort in the last permitted WAIT cycle so exactly TIMEOUT_CYCLES stall cycles elapse.
  assign abort = (state == WAIT) & ~dmem_ack & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state == IDLE) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)      mem_err <= 1'b0;
    else if (abort) mem_err <= 1'b1;
  end
`else
  assign abort   = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && is_mem) state_nx = WAIT;
      WAIT: if (done || abort)    state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall_agex = (state == WAIT);
    dmem_req   = (state == WAIT);
  end

  always_comb begin
    be_nx = 4'b1111;
    wd_nx = agex_st_data;
    if (agex_op == `LB_I || agex_op == `LBU_I || agex_op == `SB_I)
      be_nx = 4'b0001 << agex_result[1:0];
    else if (agex_op == `LH_I || agex_op == `LHU_I || agex_op == `SH_I)
      be_nx = 4'b0011 << {agex_result[1], 1'b0};
    if (agex_op == `SB_I)      wd_nx = {(DBITS/8){agex_st_data[7:0]}};
    else if (agex_op == `SH_I) wd_nx = {(DBITS/16){agex_st_data[15:0]}};
  end

  // Halfword loads align the lane down to the half boundary; words use lane 0.
  always_comb begin
    lane_sh = 5'd0;
    if (req_op == `LB_I || req_op == `LBU_I)      lane_sh = {req_lane, 3'b000};
    else if (req_op == `LH_I || req_op == `LHU_I) lane_sh = {req_lane[1], 4'b0000};
    rshift   = dmem_rdata >> lane_sh;
    load_val = rshift;
    case (req_op)
      `LB_I:   load_val = {{(DBITS-8){rshift[7]}}, rshift[7:0]};
      `LBU_I:  load_val = {{(DBITS-8){1'b0}}, rshift[7:0]};
      `LH_I:   load_val = {{(DBITS-16){rshift[15]}}, rshift[15:0]};
      `LHU_I:  load_val = {{(DBITS-16){1'b0}}, rshift[15:0]};
      default: load_val = rshift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      req_op     <= '0;
      req_lane   <= '0;
      req_rd     <= '0;
      req_wr_reg <= 1'b0;
      mem_valid  <= 1'b0;
      mem_rd     <= '0;
      mem_wr_reg <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      mem_valid <= 1'b0;
      if (accept && is_mem) begin
        dmem_addr  <= {agex_result[DBITS-1:2], 2'b00};
        dmem_be    <= be_nx;
        dmem_we    <= is_store;
        dmem_wdata <= wd_nx;
        req_op     <= agex_op;
        req_lane   <= agex_result[1:0];
        req_rd     <= agex_rd;
        req_wr_reg <= agex_wr_reg & (agex_rd != 5'd0) & ~is_store;
      end
      if (accept && !is_mem) begin
        mem_valid  <= 1'b1;
        mem_rd     <= agex_rd;
        mem_wr_reg <= agex_wr_reg & (agex_rd != 5'd0);
        mem_wdata  <= agex_result;
      end else if (done) begin
        mem_valid  <= 1'b1;
        mem_rd     <= req_rd;
        mem_wr_reg <= req_wr_reg;
        mem_wdata  <= dmem_we ? '0 : load_val;
      end else if (abort) begin
        mem_valid  <= 1'b1;
        mem_rd     <= req_rd;
        mem_wr_reg <= 1'b0;
        mem_wdata  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected writebacks; a negedge monitor checks each mem_valid pulse.
`timescale 1ns/1ps
`ifndef IOPBITS
`define IOPBITS 6
`endif
`ifndef LB_I
`define ADDI_I `IOPBITS'(1)
`define LB_I   `IOPBITS'(16)
`define LH_I   `IOPBITS'(17)
`define LW_I   `IOPBITS'(18)
`define LBU_I  `IOPBITS'(19)
`define LHU_I  `IOPBITS'(20)
`define SB_I   `IOPBITS'(21)
`define SH_I   `IOPBITS'(22)
`define SW_I   `IOPBITS'(23)
`endif

module tb_mem_stage;
  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                agex_valid = 1'b0;
  logic [`IOPBITS-1:0] agex_op = '0;
  logic [31:0]         agex_result = '0, agex_st_data = '0;
  logic [4:0]          agex_rd = '0;
  logic                agex_wr_reg = 1'b0;
  logic                stall_agex, dmem_req, dmem_we;
  logic [31:0]         dmem_addr, dmem_wdata;
  logic [3:0]          dmem_be;
  logic                dmem_ack = 1'b0;
  logic [31:0]         dmem_rdata = '0;
  logic                mem_valid, mem_wr_reg, mem_err;
  logic [4:0]          mem_rd;
  logic [31:0]         mem_wdata;

  mem_stage #(.DBITS(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .agex_valid(agex_valid), .agex_op(agex_op), .agex_result(agex_result),
    .agex_st_data(agex_st_data), .agex_rd(agex_rd), .agex_wr_reg(agex_wr_reg),
    .stall_agex(stall_agex), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wr_reg(mem_wr_reg),
    .mem_wdata(mem_wdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] data;
    logic        chk_data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic exp_err = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endfunction

  // Monitor: every writeback pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && mem_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_wb: got mem_valid=1 rd=%0d, expected no writeback", mem_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 32'(mem_rd), 32'(e.rd));
        chk("wb_wr_reg", 32'(mem_wr_reg), 32'(e.wr));
        if (e.chk_data) chk("wb_data", mem_wdata, e.data);
        chk("wb_err", 32'(mem_err), 32'(e.err));
      end
    end
  end

  task automatic push(input logic [4:0] rd, input logic wr, input logic [31:0] data, input logic cd);
    exp_t e;
    e.rd = rd; e.wr = wr; e.data = data; e.chk_data = cd; e.err = exp_err;
    exp_q.push_back(e);
  endtask

  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input logic wr, input logic exp_wr);
    push(rd, exp_wr, res, 1'b1);
    agex_valid = 1'b1; agex_op = `ADDI_I; agex_result = res; agex_rd = rd; agex_wr_reg = wr;
    @(posedge clk); #1 agex_valid = 1'b0;
    @(negedge clk);
    chk("alu_latency_valid", 32'(mem_valid), 32'd1);
    chk("alu_no_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
  endtask

  // ack_cycles = WAIT cycles including the one that carries ack (1 = same-cycle ack).
  task automatic mem_op(input logic [`IOPBITS-1:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] rd, input int ack_cycles, input logic [31:0] rdata,
                        input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                        input logic [31:0] e_wd, input logic e_wr, input logic [31:0] e_val);
    int stalls = 0;
    push(rd, e_wr, e_val, ~e_we);
    agex_valid = 1'b1; agex_op = op; agex_result = addr; agex_st_data = sd;
    agex_rd = rd; agex_wr_reg = 1'b1;
    @(posedge clk); #1 agex_valid = 1'b0;
    for (int k = 1; k <= ack_cycles; k++) begin
      @(negedge clk);
      if (stall_agex === 1'b1) stalls++;
      if (k == 1) begin
        chk("req_high", 32'(dmem_req), 32'd1);
        chk("req_we", 32'(dmem_we), 32'(e_we));
        chk("req_addr", dmem_addr, e_addr);
        chk("req_be", 32'(dmem_be), 32'(e_be));
        if (e_we) chk("req_wdata", dmem_wdata, e_wd);
      end
      if (k == ack_cycles) begin
        chk("req_addr_held", dmem_addr, e_addr);
        dmem_ack = 1'b1; dmem_rdata = rdata;
      end
      @(posedge clk); #1 dmem_ack = 1'b0; dmem_rdata = 32'h5A5A5A5A;
    end
    chk("stall_cycles", 32'(stalls), 32'(ack_cycles));
    @(negedge clk);
    chk("done_valid", 32'(mem_valid), 32'd1);
    chk("done_req_low", 32'(dmem_req), 32'd0);
    chk("done_stall_low", 32'(stall_agex), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(stall_agex), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_wr_reg", 32'(mem_wr_reg), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1;

    alu_op(32'h0000_1234, 5'd5, 1'b1, 1'b1);
    alu_op(32'h0000_0077, 5'd0, 1'b1, 1'b0);
    //     op      addr          st_data       rd  ackc rdata         e_addr        be       we    e_wd          wr    value
    mem_op(`LB_I,  32'h0000_0103, 32'h0,        5'd7, 3, 32'h80FF_FFFF, 32'h0000_0100, 4'b1000, 1'b0, 32'h0,        1'b1, 32'hFFFF_FF80);
    mem_op(`LHU_I, 32'h0000_0102, 32'h0,        5'd8, 1, 32'hBEEF_0000, 32'h0000_0100, 4'b1100, 1'b0, 32'h0,        1'b1, 32'h0000_BEEF);
    mem_op(`SB_I,  32'h0000_0201, 32'h0000_00AB, 5'd3, 2, 32'h0,        32'h0000_0200, 4'b0010, 1'b1, 32'hABAB_ABAB, 1'b0, 32'h0);
    mem_op(`SH_I,  32'h0000_0206, 32'h1234_CDEF, 5'd3, 1, 32'h0,        32'h0000_0204, 4'b1100, 1'b1, 32'hCDEF_CDEF, 1'b0, 32'h0);
    mem_op(`SW_I,  32'h0000_030B, 32'hDEAD_BEEF, 5'd2, 2, 32'h0,        32'h0000_0308, 4'b1111, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    mem_op(`LW_I,  32'h0000_0040, 32'h0,        5'd0, 2, 32'hCAFE_F00D, 32'h0000_0040, 4'b1111, 1'b0, 32'h0,        1'b0, 32'hCAFE_F00D);
    mem_op(`LH_I,  32'h0000_0001, 32'h0,        5'd9, 1, 32'h0000_8001, 32'h0000_0000, 4'b0011, 1'b0, 32'h0,        1'b1, 32'hFFFF_8001);
    mem_op(`LBU_I, 32'h0000_0101, 32'h0,        5'd10,4, 32'h0000_F100, 32'h0000_0100, 4'b0010, 1'b0, 32'h0,        1'b1, 32'h0000_00F1);

    // Ack while idle must be ignored.
    dmem_ack = 1'b1;
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_req", 32'(dmem_req), 32'd0);
    chk("idle_ack_stall", 32'(stall_agex), 32'd0);
    @(posedge clk); #1;

    // Reset during WAIT, then a late ack.
    agex_valid = 1'b1; agex_op = `LW_I; agex_result = 32'h50; agex_rd = 5'd4; agex_wr_reg = 1'b1;
    @(posedge clk); #1 agex_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall_agex), 32'd0);
    dmem_ack = 1'b1;
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_valid", 32'(mem_valid), 32'd0);
    @(posedge clk); #1;
    alu_op(32'h0000_0ABC, 5'd6, 1'b1, 1'b1);

`ifdef MEM_TIMEOUT_EN
    begin
      int stalls = 0;
      exp_err = 1'b1;
      push(5'd11, 1'b0, 32'h0, 1'b0);
      agex_valid = 1'b1; agex_op = `LW_I; agex_result = 32'h60; agex_rd = 5'd11; agex_wr_reg = 1'b1;
      @(posedge clk); #1 agex_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (stall_agex !== 1'b1) break;
        stalls++;
      end
      chk("timeout_stall_cycles", 32'(stalls), 32'd16);
      chk("timeout_valid", 32'(mem_valid), 32'd1);
      chk("timeout_req_low", 32'(dmem_req), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("timeout_err_sticky", 32'(mem_err), 32'd1);
    end
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
